// File: rtl/jcs_clkstep.sv
// Four-phase CPU clock generator and one-hot stepper, free-run or single-step.
// Optional completed-cycle counter output CYCLES when JCS_CLKSTEP_CYCLE_COUNT_EN is defined.
module jcs_clkstep #(
    parameter int NSTEPS = 6,
    parameter int DIV    = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MODE,
    input  logic              STEP_REQ,
    input  logic              HALT,
    input  logic              SRST,
    output logic              clk,
    output logic              clkd,
    output logic              clke,
    output logic              clks,
    output logic [NSTEPS-1:0] STEP,
    output logic [1:0]        PHASE,
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
    output logic              BUSY,
    output logic [31:0]       CYCLES
`else
    output logic              BUSY
`endif
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [NSTEPS-1:0] STEP_ONE = NSTEPS'(1);

    typedef enum logic [2:0] {S_IDLE, S_Q0, S_Q1, S_Q2, S_Q3} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [NSTEPS-1:0]  step_q, step_d;
    logic               pend_q, pend_d;
    logic               srst_q, srst_d;
    logic               clk_q, clk_d;
    logic               clkd_q, clkd_d;
    logic               clke_q, clke_d;
    logic               clks_q, clks_d;
    logic [1:0]         phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               last_q;
    logic               start;
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
    logic [31:0]        cycles_q, cycles_d;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        step_d  = step_q;
        pend_d  = pend_q;
        srst_d  = srst_q;
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
        cycles_d = cycles_q;
`endif
        last_q = (presc_q == PRESC_LAST);
        start  = !HALT && (!MODE || pend_q || STEP_REQ);

        if (state_q != S_IDLE) begin
            srst_d = srst_q | SRST;
            pend_d = MODE & (pend_q | STEP_REQ);
        end else if (!MODE) begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (SRST) step_d = STEP_ONE;
                if (start) begin
                    state_d = S_Q0;
                    presc_d = '0;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                if (!last_q) begin
                    presc_d = presc_q + 1'b1;
                end else begin
                    presc_d = '0;
                    unique case (state_q)
                        S_Q0: state_d = S_Q1;
                        S_Q1: state_d = S_Q2;
                        S_Q2: state_d = S_Q3;
                        default: begin
                            // Cycle boundary: the only place STEP moves while running.
                            step_d = (srst_q || SRST) ? STEP_ONE
                                                      : {step_q[NSTEPS-2:0], step_q[NSTEPS-1]};
                            srst_d = 1'b0;
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
                            cycles_d = cycles_q + 32'd1;
`endif
                            if (start) begin
                                state_d = S_Q0;
                                pend_d  = 1'b0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops.
    always_comb begin
        clk_d   = 1'b0;
        clkd_d  = 1'b0;
        phase_d = 2'd3;
        busy_d  = 1'b1;
        unique case (state_d)
            S_Q0: begin clk_d = 1'b1; phase_d = 2'd0; end
            S_Q1: begin clk_d = 1'b1; clkd_d = 1'b1; phase_d = 2'd1; end
            S_Q2: begin clkd_d = 1'b1; phase_d = 2'd2; end
            S_Q3: phase_d = 2'd3;
            default: busy_d = 1'b0;
        endcase
        clke_d = clk_d | clkd_d;
        clks_d = clk_d & clkd_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            step_q  <= STEP_ONE;
            pend_q  <= 1'b0;
            srst_q  <= 1'b0;
            clk_q   <= 1'b0;
            clkd_q  <= 1'b0;
            clke_q  <= 1'b0;
            clks_q  <= 1'b0;
            phase_q <= 2'd3;
            busy_q  <= 1'b0;
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
            cycles_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            srst_q  <= srst_d;
            clk_q   <= clk_d;
            clkd_q  <= clkd_d;
            clke_q  <= clke_d;
            clks_q  <= clks_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
            cycles_q <= cycles_d;
`endif
        end
    end

    assign clk   = clk_q;
    assign clkd  = clkd_q;
    assign clke  = clke_q;
    assign clks  = clks_q;
    assign STEP  = step_q;
    assign PHASE = phase_q;
    assign BUSY  = busy_q;
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
    assign CYCLES = cycles_q;
`endif

endmodule

// File: tb/tb_jcs_clkstep.sv
// Bench for jcs_clkstep: vector table, directed corner sequences, then random
// stimulus against a cycle-position reference model.
module tb_jcs_clkstep;

    localparam int NSTEPS = 6;
    localparam int DIV    = 2;
    localparam int VW     = NSTEPS + 7;

    logic CLK = 1'b0;
    logic RESET, MODE, STEP_REQ, HALT, SRST;
    logic clk, clkd, clke, clks, BUSY;
    logic [NSTEPS-1:0] STEP;
    logic [1:0] PHASE;
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
    logic [31:0] CYCLES;
`endif

    always #5 CLK = ~CLK;

    jcs_clkstep #(.NSTEPS(NSTEPS), .DIV(DIV)) dut (
        .CLK(CLK), .RESET(RESET), .MODE(MODE), .STEP_REQ(STEP_REQ),
        .HALT(HALT), .SRST(SRST),
        .clk(clk), .clkd(clkd), .clke(clke), .clks(clks),
        .STEP(STEP), .PHASE(PHASE),
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
        .BUSY(BUSY), .CYCLES(CYCLES)
`else
        .BUSY(BUSY)
`endif
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {BUSY, PHASE, clk, clkd, clke, clks, STEP};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the cycle (-1 = idle), step index.
    int          m_pos  = -1;
    int          m_step = 0;
    bit          m_pend = 0;
    bit          m_srl  = 0;
    int unsigned m_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit want_start();
        return !HALT && (!MODE || m_pend || STEP_REQ);
    endfunction

    task automatic model_step();
        if (RESET) begin
            m_pos = -1; m_step = 0; m_pend = 0; m_srl = 0; m_cyc = 0;
        end else if (m_pos < 0) begin
            if (SRST) m_step = 0;
            if (want_start()) begin m_pos = 0; m_pend = 0; end
            else if (!MODE) m_pend = 0;
        end else if (m_pos < 4*DIV-1) begin
            m_pos++;
            m_srl  = m_srl | SRST;
            m_pend = MODE && (m_pend || STEP_REQ);
        end else begin
            m_step = (m_srl || SRST) ? 0 : (m_step + 1) % NSTEPS;
            m_srl  = 0;
            m_cyc++;
            if (want_start()) begin m_pos = 0; m_pend = 0; end
            else begin m_pos = -1; m_pend = MODE && (m_pend || STEP_REQ); end
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        bit b, c, cd;
        int ph;
        b  = (m_pos >= 0);
        ph = b ? m_pos / DIV : 3;
        c  = b && (ph < 2);
        cd = b && (ph == 1 || ph == 2);
        return {b, 2'(ph), c, cd, c | cd, c & cd, NSTEPS'(1 << m_step)};
    endfunction

    task automatic tick(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        chk(tag, 32'(dut_vec), 32'(model_vec()));
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
        chk({tag, "_cycles"}, CYCLES, m_cyc);
`endif
    endtask

    task automatic rst_release();
        RESET = 1; MODE = 0; HALT = 0; STEP_REQ = 0; SRST = 0;
        tick("reset");
        RESET = 0;
    endtask

    typedef struct {
        logic rst, mode, halt, req, srst;
        logic [VW-1:0] exp;
    } vec_t;

    localparam logic [VW-1:0] IDLE1 = {1'b0, 2'd3, 4'b0000, 6'b000001};
    localparam logic [VW-1:0] Q0_1  = {1'b1, 2'd0, 4'b1010, 6'b000001};
    localparam logic [VW-1:0] Q1_1  = {1'b1, 2'd1, 4'b1111, 6'b000001};
    localparam logic [VW-1:0] Q2_1  = {1'b1, 2'd2, 4'b0110, 6'b000001};
    localparam logic [VW-1:0] Q3_1  = {1'b1, 2'd3, 4'b0000, 6'b000001};
    localparam logic [VW-1:0] IDLE2 = {1'b0, 2'd3, 4'b0000, 6'b000010};

    vec_t tbl[13];

    initial begin
        RESET = 1; MODE = 0; HALT = 0; STEP_REQ = 0; SRST = 0;

        // Single-step cycle, then SRST in idle.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, IDLE1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, Q0_1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Q0_1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Q1_1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Q1_1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Q2_1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Q2_1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Q3_1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Q3_1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE2};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, IDLE1};
        for (int i = 0; i < 13; i++) begin
            RESET = tbl[i].rst; MODE = tbl[i].mode; HALT = tbl[i].halt;
            STEP_REQ = tbl[i].req; SRST = tbl[i].srst;
            tick("tbl_model");
            chk($sformatf("tbl_row%0d", i), 32'(dut_vec), 32'(tbl[i].exp));
        end
        STEP_REQ = 0; SRST = 0;

        // Free run: start on first CLK after reset, seven boundaries.
        rst_release();
        tick("fr");
        chk("fr_start", {29'd0, BUSY, PHASE}, {29'd0, 1'b1, 2'd0});
        repeat (56) tick("fr");
        chk("fr_step7", 32'(STEP), 32'h02);
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
        chk("fr_cycles7", CYCLES, 32'd7);
`endif

        // Single step with three request pulses inside the cycle.
        rst_release();
        MODE = 1; STEP_REQ = 1; tick("ss"); STEP_REQ = 0;
        repeat (2) tick("ss");
        for (int k = 0; k < 3; k++) begin
            STEP_REQ = 1; tick("ss_req"); STEP_REQ = 0;
            if (k < 2) tick("ss_req");
        end
        repeat (20) tick("ss");
        chk("ss_step2", {26'd0, STEP}, 32'h04);
        chk("ss_idle", {29'd0, BUSY, PHASE}, {29'd0, 1'b0, 2'd3});

        // SRST in Q2 of the STEP=001000 cycle, then HALT raised in Q1.
        rst_release();
        repeat (29) tick("sr");
        chk("sr_step_before", {26'd0, STEP}, 32'h08);
        chk("sr_phase_q2", {30'd0, PHASE}, 32'd2);
        SRST = 1; tick("sr"); SRST = 0;
        repeat (3) tick("sr");
        chk("sr_step_after", {26'd0, STEP}, 32'h01);
        chk("sr_phase_q0", {30'd0, PHASE}, 32'd0);
        repeat (2) tick("ht");
        HALT = 1;
        repeat (6) tick("ht");
        chk("ht_idle", {28'd0, BUSY, PHASE, clk}, {28'd0, 1'b0, 2'd3, 1'b0});
        chk("ht_step", {26'd0, STEP}, 32'h02);
        tick("ht");
        chk("ht_stay", {31'd0, BUSY}, 32'd0);
        HALT = 0; tick("ht");
        chk("ht_resume", {29'd0, BUSY, PHASE}, {29'd0, 1'b1, 2'd0});

        // Reset in the middle of a cycle.
        rst_release();
        repeat (21) tick("mr");
        chk("mr_pre_step", {26'd0, STEP}, 32'h04);
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
        chk("mr_pre_cycles", CYCLES, 32'd2);
`endif
        RESET = 1; tick("mr");
        chk("mr_reset", 32'(dut_vec), 32'(IDLE1));
`ifdef JCS_CLKSTEP_CYCLE_COUNT_EN
        chk("mr_cycles0", CYCLES, 32'd0);
`endif
        RESET = 0; MODE = 1; tick("mr");
        chk("mr_no_pending", {31'd0, BUSY}, 32'd0);

        // Random stimulus against the model.
        rst_release();
        for (int n = 0; n < 3000; n++) begin
            RESET    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) MODE = ~MODE;
            if ($urandom_range(0, 29) == 0) HALT = ~HALT;
            STEP_REQ = ($urandom_range(0, 7) == 0);
            SRST     = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
